// File: rtl/hls_run_sequencer.sv
// hls_run_sequencer: drives an HLS top (Bambu start/done) through a
// campaign of back-to-back runs and collects per-run latency statistics.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   cfg_start           pulse to begin a campaign (ignored while busy)
//   cfg_num_runs        number of runs, sampled with cfg_start
//   cfg_timeout         per-run cycle limit, 0 selects DEF_TIMEOUT
//   dut_reset_n         active-low reset to the HLS top
//   dut_start_port      one-cycle start pulse to the HLS top
//   dut_done_port       done from the HLS top
//   busy                campaign in progress
//   res_valid           one-cycle pulse, res_* describe the finished run
//   res_run_idx         0-based index of the reported run
//   res_cycles          latency (or timeout limit) of the reported run
//   res_timeout         reported run hit the timeout
//   all_done            one-cycle pulse at the end of the campaign
//   runs_ok, runs_to    completed / timed-out run counters
//   min_cycles          minimum latency over completed runs
//   max_cycles          maximum latency over completed runs
//   total_cycles        saturating latency sum over completed runs

module hls_run_sequencer #(
    parameter int              CNT_W       = 32,
    parameter int              TOT_W       = 48,
    parameter int              RUNS_W      = 8,
    parameter longint unsigned DEF_TIMEOUT = 200000000,
    parameter int              DUT_RST_CYC = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [RUNS_W-1:0] cfg_num_runs,
    input  logic [CNT_W-1:0]  cfg_timeout,
    output logic              dut_reset_n,
    output logic              dut_start_port,
    input  logic              dut_done_port,
    output logic              busy,
    output logic              res_valid,
    output logic [RUNS_W-1:0] res_run_idx,
    output logic [CNT_W-1:0]  res_cycles,
    output logic              res_timeout,
    output logic              all_done,
    output logic [RUNS_W-1:0] runs_ok,
    output logic [RUNS_W-1:0] runs_to,
    output logic [CNT_W-1:0]  min_cycles,
    output logic [CNT_W-1:0]  max_cycles,
    output logic [TOT_W-1:0]  total_cycles
);

    localparam logic [CNT_W-1:0] DEF_TO = CNT_W'(DEF_TIMEOUT);

    localparam int RC_W = (DUT_RST_CYC > 1) ? $clog2(DUT_RST_CYC) : 1;

    localparam logic [RC_W-1:0] RC_LAST = RC_W'(DUT_RST_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DUT_RST,
        S_START,
        S_WAIT,
        S_REPORT,
        S_FINISH
    } state_t;

    state_t            state;
    logic [RUNS_W-1:0] num_runs_q;
    logic [RUNS_W-1:0] run_idx;
    logic [CNT_W-1:0]  timeout_q;
    logic [CNT_W-1:0]  cnt;
    logic [RC_W-1:0]   rst_cnt;

    logic [CNT_W-1:0]  eff_timeout;
    logic              in_run;
    logic              hit_done;
    logic              hit_to;
    logic [TOT_W:0]    sum_ext;
    logic [TOT_W-1:0]  total_next;
    logic              first_ok;
    logic [CNT_W-1:0]  min_next;
    logic [CNT_W-1:0]  max_next;
    logic              last_run;

    always_comb begin
        eff_timeout = (cfg_timeout == '0) ? DEF_TO : cfg_timeout;

        // done is only meaningful while a run is in flight
        in_run   = (state == S_START) || (state == S_WAIT);
        hit_done = in_run && dut_done_port;
        // a done arriving on the timeout cycle still counts as completed
        hit_to   = in_run && !dut_done_port && (cnt == timeout_q);

        // one extra bit catches the carry used for saturation
        sum_ext    = {1'b0, total_cycles} + (TOT_W + 1)'(cnt);
        total_next = sum_ext[TOT_W] ? '1 : sum_ext[TOT_W-1:0];

        // the first completed run seeds both extremes
        first_ok = (runs_ok == '0);
        min_next = (first_ok || cnt < min_cycles) ? cnt : min_cycles;
        max_next = (first_ok || cnt > max_cycles) ? cnt : max_cycles;

        last_run = (run_idx == num_runs_q - 1'b1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            num_runs_q     <= '0;
            run_idx        <= '0;
            timeout_q      <= '0;
            cnt            <= '0;
            rst_cnt        <= '0;
            dut_reset_n    <= 1'b0;
            dut_start_port <= 1'b0;
            busy           <= 1'b0;
            res_valid      <= 1'b0;
            res_run_idx    <= '0;
            res_cycles     <= '0;
            res_timeout    <= 1'b0;
            all_done       <= 1'b0;
            runs_ok        <= '0;
            runs_to        <= '0;
            min_cycles     <= '0;
            max_cycles     <= '0;
            total_cycles   <= '0;
        end else begin
            res_valid      <= 1'b0;
            all_done       <= 1'b0;
            dut_start_port <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        num_runs_q   <= cfg_num_runs;
                        timeout_q    <= eff_timeout;
                        run_idx      <= '0;
                        runs_ok      <= '0;
                        runs_to      <= '0;
                        min_cycles   <= '0;
                        max_cycles   <= '0;
                        total_cycles <= '0;
                        busy         <= 1'b1;
                        if (cfg_num_runs == '0) begin
                            state    <= S_FINISH;
                            all_done <= 1'b1;
                        end else begin
                            state       <= S_DUT_RST;
                            dut_reset_n <= 1'b0;
                            rst_cnt     <= '0;
                        end
                    end
                end

                S_DUT_RST: begin
                    if (rst_cnt == RC_LAST) begin
                        state          <= S_START;
                        dut_reset_n    <= 1'b1;
                        dut_start_port <= 1'b1;
                        cnt            <= CNT_W'(1);
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end

                S_START, S_WAIT: begin
                    if (hit_done) begin
                        state        <= S_REPORT;
                        res_valid    <= 1'b1;
                        res_run_idx  <= run_idx;
                        res_cycles   <= cnt;
                        res_timeout  <= 1'b0;
                        runs_ok      <= runs_ok + 1'b1;
                        min_cycles   <= min_next;
                        max_cycles   <= max_next;
                        total_cycles <= total_next;
                    end else if (hit_to) begin
                        state       <= S_REPORT;
                        res_valid   <= 1'b1;
                        res_run_idx <= run_idx;
                        res_cycles  <= timeout_q;
                        res_timeout <= 1'b1;
                        runs_to     <= runs_to + 1'b1;
                    end else begin
                        state <= S_WAIT;
                        cnt   <= cnt + 1'b1;
                    end
                end

                S_REPORT: begin
                    if (last_run) begin
                        state    <= S_FINISH;
                        all_done <= 1'b1;
                    end else begin
                        state       <= S_DUT_RST;
                        run_idx     <= run_idx + 1'b1;
                        dut_reset_n <= 1'b0;
                        rst_cnt     <= '0;
                    end
                end

                S_FINISH: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hls_run_sequencer.sv
// tb_hls_run_sequencer: directed campaigns against a behavioural HLS top
// whose done latency per run comes from lat_tab (0 = never done).

module tb_hls_run_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_start = 1'b0;
    logic [7:0]  cfg_num_runs = '0;
    logic [31:0] cfg_timeout = '0;
    logic        dut_reset_n;
    logic        dut_start_port;
    logic        dut_done_port = 1'b0;
    logic        busy;
    logic        res_valid;
    logic [7:0]  res_run_idx;
    logic [31:0] res_cycles;
    logic        res_timeout;
    logic        all_done;
    logic [7:0]  runs_ok;
    logic [7:0]  runs_to;
    logic [31:0] min_cycles;
    logic [31:0] max_cycles;
    logic [47:0] total_cycles;

    hls_run_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .cfg_start      (cfg_start),
        .cfg_num_runs   (cfg_num_runs),
        .cfg_timeout    (cfg_timeout),
        .dut_reset_n    (dut_reset_n),
        .dut_start_port (dut_start_port),
        .dut_done_port  (dut_done_port),
        .busy           (busy),
        .res_valid      (res_valid),
        .res_run_idx    (res_run_idx),
        .res_cycles     (res_cycles),
        .res_timeout    (res_timeout),
        .all_done       (all_done),
        .runs_ok        (runs_ok),
        .runs_to        (runs_to),
        .min_cycles     (min_cycles),
        .max_cycles     (max_cycles),
        .total_cycles   (total_cycles)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    int lat_tab[8];
    int si = 0;
    int rc = 0;
    int cur = 0;
    bit act = 0;

    // behavioural HLS top: done is raised when the cycle count since
    // the start cycle (start cycle = 1) reaches the run's latency
    always @(negedge clock) begin
        if (dut_done_port) begin
            dut_done_port = 1'b0;
            act = 0;
        end
        if (!dut_reset_n) begin
            act = 0;
        end else if (dut_start_port) begin
            rc  = 1;
            cur = (si < 8) ? lat_tab[si] : 0;
            si++;
            act = 1;
            dut_done_port = (cur == 1);
        end else if (act) begin
            rc++;
            dut_done_port = (cur != 0) && (rc == cur);
        end
    end

    int r_n = 0;
    int r_idx[16];
    int r_cyc[16];
    int r_to[16];
    int done_n = 0;
    int starts = 0;
    int lo_cnt = 0;

    always @(negedge clock) begin
        if (res_valid && r_n < 16) begin
            r_idx[r_n] = int'(res_run_idx);
            r_cyc[r_n] = int'(res_cycles);
            r_to[r_n]  = int'(res_timeout);
            r_n++;
        end
        if (all_done) done_n++;
        if (dut_start_port) begin
            starts++;
            chk("rst_low_cycles", 64'(lo_cnt), 64'd2);
            lo_cnt = 0;
        end else if (!dut_reset_n && busy) begin
            lo_cnt++;
        end else begin
            lo_cnt = 0;
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rstn"}, 64'(dut_reset_n), 64'd0);
        chk({tag, "_start"}, 64'(dut_start_port), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_rvalid"}, 64'(res_valid), 64'd0);
        chk({tag, "_ridx"}, 64'(res_run_idx), 64'd0);
        chk({tag, "_rcyc"}, 64'(res_cycles), 64'd0);
        chk({tag, "_rto"}, 64'(res_timeout), 64'd0);
        chk({tag, "_alldone"}, 64'(all_done), 64'd0);
        chk({tag, "_ok"}, 64'(runs_ok), 64'd0);
        chk({tag, "_to"}, 64'(runs_to), 64'd0);
        chk({tag, "_min"}, 64'(min_cycles), 64'd0);
        chk({tag, "_max"}, 64'(max_cycles), 64'd0);
        chk({tag, "_tot"}, 64'(total_cycles), 64'd0);
    endtask

    // launch a campaign; poke>0 re-pulses cfg_start that many cycles in
    task automatic campaign(input int n, input int to, input int l0,
                            input int l1, input int l2, input int poke);
        int k;
        lat_tab[0] = l0;
        lat_tab[1] = l1;
        lat_tab[2] = l2;
        si = 0;
        r_n = 0;
        starts = 0;
        cfg_num_runs = 8'(n);
        cfg_timeout = 32'(to);
        cfg_start = 1'b1;
        @(negedge clock);
        cfg_start = 1'b0;
        if (poke > 0) begin
            repeat (poke) @(negedge clock);
            cfg_num_runs = 8'd5;
            cfg_timeout = 32'd3;
            cfg_start = 1'b1;
            @(negedge clock);
            cfg_start = 1'b0;
        end
        k = 0;
        while (!all_done && k < 2000) begin
            @(negedge clock);
            k++;
        end
        chk("campaign_finished", 64'(all_done), 64'd1);
        @(negedge clock);
    endtask

    initial begin
        int d0;
        int k;
        foreach (lat_tab[i]) lat_tab[i] = 0;

        repeat (3) @(negedge clock);
        chk_reset_vals("por");
        reset = 1'b0;
        @(negedge clock);

        d0 = done_n;
        campaign(3, 0, 11, 11, 11, 0);
        chk("t1_nres", 64'(r_n), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_idx", 64'(r_idx[i]), 64'(i));
            chk("t1_cyc", 64'(r_cyc[i]), 64'd11);
            chk("t1_to", 64'(r_to[i]), 64'd0);
        end
        chk("t1_min", 64'(min_cycles), 64'd11);
        chk("t1_max", 64'(max_cycles), 64'd11);
        chk("t1_tot", 64'(total_cycles), 64'd33);
        chk("t1_ok", 64'(runs_ok), 64'd3);
        chk("t1_runs_to", 64'(runs_to), 64'd0);
        chk("t1_alldone_n", 64'(done_n - d0), 64'd1);
        chk("t1_starts", 64'(starts), 64'd3);
        chk("t1_idle", 64'(busy), 64'd0);

        campaign(3, 0, 5, 20, 8, 0);
        chk("t3_cyc0", 64'(r_cyc[0]), 64'd5);
        chk("t3_cyc1", 64'(r_cyc[1]), 64'd20);
        chk("t3_cyc2", 64'(r_cyc[2]), 64'd8);
        chk("t3_min", 64'(min_cycles), 64'd5);
        chk("t3_max", 64'(max_cycles), 64'd20);
        chk("t3_tot", 64'(total_cycles), 64'd33);

        campaign(2, 50, 0, 0, 0, 0);
        chk("t2_nres", 64'(r_n), 64'd2);
        for (int i = 0; i < 2; i++) begin
            chk("t2_to", 64'(r_to[i]), 64'd1);
            chk("t2_cyc", 64'(r_cyc[i]), 64'd50);
        end
        chk("t2_runs_to", 64'(runs_to), 64'd2);
        chk("t2_ok", 64'(runs_ok), 64'd0);
        chk("t2_min", 64'(min_cycles), 64'd0);
        chk("t2_max", 64'(max_cycles), 64'd0);
        chk("t2_tot", 64'(total_cycles), 64'd0);

        campaign(1, 0, 1, 0, 0, 0);
        chk("b1_cyc", 64'(r_cyc[0]), 64'd1);
        chk("b1_to", 64'(r_to[0]), 64'd0);
        chk("b1_ok", 64'(runs_ok), 64'd1);

        campaign(1, 7, 7, 0, 0, 0);
        chk("b7_cyc", 64'(r_cyc[0]), 64'd7);
        chk("b7_to", 64'(r_to[0]), 64'd0);
        chk("b7_ok", 64'(runs_ok), 64'd1);

        campaign(1, 7, 8, 0, 0, 0);
        chk("b8_cyc", 64'(r_cyc[0]), 64'd7);
        chk("b8_to", 64'(r_to[0]), 64'd1);
        chk("b8_runs_to", 64'(runs_to), 64'd1);

        starts = 0;
        r_n = 0;
        cfg_num_runs = 8'd0;
        cfg_timeout = 32'd0;
        cfg_start = 1'b1;
        @(negedge clock);
        cfg_start = 1'b0;
        chk("n0_alldone", 64'(all_done), 64'd1);
        chk("n0_busy", 64'(busy), 64'd1);
        chk("n0_runs_to", 64'(runs_to), 64'd0);
        @(negedge clock);
        chk("n0_pulse_end", 64'(all_done), 64'd0);
        chk("n0_idle", 64'(busy), 64'd0);
        repeat (3) @(negedge clock);
        chk("n0_starts", 64'(starts), 64'd0);
        chk("n0_nres", 64'(r_n), 64'd0);

        campaign(2, 0, 10, 10, 0, 6);
        chk("ovl_nres", 64'(r_n), 64'd2);
        chk("ovl_cyc0", 64'(r_cyc[0]), 64'd10);
        chk("ovl_cyc1", 64'(r_cyc[1]), 64'd10);
        chk("ovl_ok", 64'(runs_ok), 64'd2);
        chk("ovl_starts", 64'(starts), 64'd2);

        lat_tab[0] = 0;
        lat_tab[1] = 0;
        si = 0;
        r_n = 0;
        starts = 0;
        cfg_num_runs = 8'd3;
        cfg_timeout = 32'd30;
        cfg_start = 1'b1;
        @(negedge clock);
        cfg_start = 1'b0;
        k = 0;
        while (starts < 2 && k < 500) begin
            @(negedge clock);
            k++;
        end
        chk("mr_second_start", 64'(starts), 64'd2);
        repeat (5) @(negedge clock);
        chk("mr_first_to", 64'(runs_to), 64'd1);
        chk("mr_first_cyc", 64'(res_cycles), 64'd30);
        d0 = done_n;
        reset = 1'b1;
        @(negedge clock);
        chk_reset_vals("mr");
        reset = 1'b0;
        repeat (80) @(negedge clock);
        chk("mr_no_alldone", 64'(done_n - d0), 64'd0);
        chk("mr_no_res", 64'(r_n), 64'd1);
        chk("mr_no_start", 64'(starts), 64'd2);
        chk("mr_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
